// File: rtl/led_driver.sv
// Multi-channel LED driver: per-channel OFF/ON/PWM/BLINK modes.
// Duty values are double-buffered and only take effect at a PWM period
// boundary. Outputs are registered, and their polarity can be inverted
// so they can drive active-low pins directly.
module led_driver #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1,
  parameter int BLINK_BIT  = 23,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_48mhz,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic [CHANNELS-1:0] led_out,
  output logic                pwm_wrap
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  logic [PSW-1:0]      presc_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wrap;
  logic [BLINK_BIT:0]  blink_cnt;
  logic                blink_phase;

  mode_t               mode        [CHANNELS];
  logic [PWM_BITS-1:0] duty_shadow [CHANNELS];
  logic [PWM_BITS-1:0] duty_active [CHANNELS];
  logic [CHANNELS-1:0] lit;

  // With PRESCALE = 1 the compare value is 0 and the counter never leaves 0,
  // so tick is permanently high.
  assign tick        = (presc_cnt == PSW'(PRESCALE - 1));
  assign wrap        = tick && (pwm_cnt == {PWM_BITS{1'b1}});
  assign blink_phase = blink_cnt[BLINK_BIT];

  // Prescaler: divides the clock down to one PWM step per tick.
  always_ff @(posedge clk_48mhz) begin
    if (reset)     presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + 1'b1;
  end

  // PWM counter: advances on tick and wraps naturally at its width.
  always_ff @(posedge clk_48mhz) begin
    if (reset)     pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Blink counter: free-running; its top bit is the blink phase.
  always_ff @(posedge clk_48mhz) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_cnt + 1'b1;
  end

  // Channel registers: mode and shadow duty load on a write. Active duty
  // loads only at the wrap edge, taking a same-edge write directly so that
  // the write is not delayed by a whole period.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]        <= MODE_OFF;
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_ch == CW'(i))) begin
          mode[i]        <= mode_t'(wr_mode);
          duty_shadow[i] <= wr_duty;
        end
        if (wrap) begin
          if (wr_en && (wr_ch == CW'(i))) duty_active[i] <= wr_duty;
          else                            duty_active[i] <= duty_shadow[i];
        end
      end
    end
  end

  // Lit decision per channel, evaluated from the current (pre-edge) state.
  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[i])
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_PWM:   lit[i] = (pwm_cnt < duty_active[i]);
        MODE_BLINK: lit[i] = blink_phase && (pwm_cnt < duty_active[i]);
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  // Registered outputs: polarity-adjusted LED drive and period-start pulse.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      led_out  <= {CHANNELS{ACTIVE_LOW}};
      pwm_wrap <= 1'b0;
    end else begin
      led_out  <= lit ^ {CHANNELS{ACTIVE_LOW}};
      pwm_wrap <= wrap;
    end
  end

endmodule

// File: tb/tb_led_driver.sv
// Directed testbench for led_driver. The main instance uses PRESCALE = 1
// and BLINK_BIT = 4. A second instance on the same inputs uses PRESCALE = 4.
`timescale 1ns/1ps
module tb_led_driver;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       wr_en     = 1'b0;
  logic [1:0] wr_ch     = '0;
  logic [1:0] wr_mode   = '0;
  logic [7:0] wr_duty   = '0;
  logic [2:0] led_out;
  logic       pwm_wrap;
  logic [2:0] p4_led;
  logic       p4_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk_48mhz = ~clk_48mhz;

  led_driver #(.CHANNELS(3), .PWM_BITS(8), .PRESCALE(1), .BLINK_BIT(4), .ACTIVE_LOW(1'b1)) u_dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .led_out(led_out), .pwm_wrap(pwm_wrap)
  );

  led_driver #(.CHANNELS(3), .PWM_BITS(8), .PRESCALE(4), .BLINK_BIT(4), .ACTIVE_LOW(1'b1)) u_p4 (
    .clk_48mhz(clk_48mhz), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .led_out(p4_led), .pwm_wrap(p4_wrap)
  );

  task automatic step();
    @(posedge clk_48mhz);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] duty);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_mode = mode;
    wr_duty = duty;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_mode = 2'd1; wr_duty = 8'hff;
    step(); step(); step();
    n_checks++; if (led_out !== 3'b111) begin n_fail++; $display("FAIL reset_led actual=%b required=111", led_out); end
    n_checks++; if (pwm_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap actual=%b required=0", pwm_wrap); end
    n_checks++; if (p4_led !== 3'b111) begin n_fail++; $display("FAIL reset_p4_led actual=%b required=111", p4_led); end
    reset = 1'b0; wr_en = 1'b0; cyc = 0;
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (led_out !== 3'b111) begin n_fail++; $display("FAIL reset_write_lost actual=%b required=111", led_out); end
    n_checks++; if (pwm_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_after actual=%b required=0", pwm_wrap); end
  endtask

  task automatic test_pwm_duty();
    int lit_n, first_lit, last_lit, wrap_at, others;
    do_reset();
    wr(2'd1, 2'd2, 8'd64);
    while (!pwm_wrap && cyc < 600) step();
    n_checks++; if (pwm_wrap !== 1'b1 || cyc != 256) begin n_fail++; $display("FAIL pwm_first_wrap actual_cyc=%0d wrap=%b required_cyc=256", cyc, pwm_wrap); end
    lit_n = 0; first_lit = 0; last_lit = -1; wrap_at = -1; others = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led_out[1] === 1'b0) begin lit_n++; last_lit = i; end
      if (i == 0) first_lit = (led_out[1] === 1'b0);
      if (pwm_wrap === 1'b1 && wrap_at < 0) wrap_at = i;
      if (led_out[0] !== 1'b1 || led_out[2] !== 1'b1) others++;
    end
    n_checks++; if (lit_n != 64) begin n_fail++; $display("FAIL pwm_lit_count actual=%0d required=64", lit_n); end
    n_checks++; if (first_lit != 1) begin n_fail++; $display("FAIL pwm_lit_start actual=%0d required=1", first_lit); end
    n_checks++; if (last_lit != 63) begin n_fail++; $display("FAIL pwm_lit_end actual=%0d required=63", last_lit); end
    n_checks++; if (wrap_at != 255) begin n_fail++; $display("FAIL pwm_wrap_spacing actual=%0d required=255", wrap_at); end
    n_checks++; if (others != 0) begin n_fail++; $display("FAIL pwm_other_channels actual=%0d required=0", others); end
  endtask

  task automatic test_shadow();
    int lit_n;
    do_reset();
    wr(2'd0, 2'd2, 8'd200);
    while (!pwm_wrap && cyc < 600) step();
    n_checks++; if (pwm_wrap !== 1'b1) begin n_fail++; $display("FAIL shadow_wait_wrap actual=%b required=1", pwm_wrap); end
    lit_n = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin wr_en = 1'b1; wr_ch = 2'd0; wr_mode = 2'd2; wr_duty = 8'd10; end
      step();
      wr_en = 1'b0;
      if (led_out[0] === 1'b0) lit_n++;
    end
    n_checks++; if (lit_n != 200) begin n_fail++; $display("FAIL shadow_current_period actual=%0d required=200", lit_n); end
    lit_n = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led_out[0] === 1'b0) lit_n++;
    end
    n_checks++; if (lit_n != 10) begin n_fail++; $display("FAIL shadow_next_period actual=%0d required=10", lit_n); end
    lit_n = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin wr_en = 1'b1; wr_ch = 2'd0; wr_mode = 2'd2; wr_duty = 8'd50; end
      step();
      wr_en = 1'b0;
      if (led_out[0] === 1'b0) lit_n++;
    end
    n_checks++; if (lit_n != 10) begin n_fail++; $display("FAIL shadow_before_wrap_write actual=%0d required=10", lit_n); end
    lit_n = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led_out[0] === 1'b0) lit_n++;
    end
    n_checks++; if (lit_n != 50) begin n_fail++; $display("FAIL shadow_wrap_edge_forward actual=%0d required=50", lit_n); end
  endtask

  task automatic test_blink();
    int lit_n, bad;
    logic exp_lit;
    do_reset();
    wr(2'd2, 2'd3, 8'd255);
    while (!pwm_wrap && cyc < 600) step();
    n_checks++; if (pwm_wrap !== 1'b1) begin n_fail++; $display("FAIL blink_wait_wrap actual=%b required=1", pwm_wrap); end
    lit_n = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      exp_lit = ((i % 32) >= 16) && (i < 255);
      if ((led_out[2] === 1'b0) !== exp_lit) bad++;
      if (led_out[2] === 1'b0) lit_n++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL blink_pattern mismatches=%0d required=0", bad); end
    n_checks++; if (lit_n != 127) begin n_fail++; $display("FAIL blink_lit_count actual=%0d required=127", lit_n); end
  endtask

  task automatic test_edges();
    int bad;
    do_reset();
    wr(2'd0, 2'd1, 8'd0);
    n_checks++; if (led_out[0] !== 1'b1) begin n_fail++; $display("FAIL on_latency actual=%b required=1", led_out[0]); end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (led_out[0] !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL on_always_lit dark_cycles=%0d required=0", bad); end
    wr(2'd1, 2'd2, 8'd0);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (led_out[1] !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL duty0_never_lit lit_cycles=%0d required=0", bad); end
    wr(2'd3, 2'd1, 8'd255);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (led_out !== 3'b110) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bad_channel_ignored changed_cycles=%0d required=0", bad); end
  endtask

  task automatic test_prescale();
    int lit_n, wrap_at;
    do_reset();
    wr(2'd1, 2'd2, 8'd64);
    while (!p4_wrap && cyc < 1500) step();
    n_checks++; if (p4_wrap !== 1'b1 || cyc != 1024) begin n_fail++; $display("FAIL p4_first_wrap actual_cyc=%0d wrap=%b required_cyc=1024", cyc, p4_wrap); end
    lit_n = 0; wrap_at = -1;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (p4_led[1] === 1'b0) lit_n++;
      if (p4_wrap === 1'b1 && wrap_at < 0) wrap_at = i;
    end
    n_checks++; if (lit_n != 256) begin n_fail++; $display("FAIL p4_lit_count actual=%0d required=256", lit_n); end
    n_checks++; if (wrap_at != 1023) begin n_fail++; $display("FAIL p4_wrap_spacing actual=%0d required=1023", wrap_at); end
  endtask

  task automatic test_mid_reset();
    int bad;
    do_reset();
    wr(2'd0, 2'd2, 8'd128);
    wr(2'd1, 2'd2, 8'd128);
    wr(2'd2, 2'd2, 8'd128);
    while (!pwm_wrap && cyc < 600) step();
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (led_out !== 3'b000) begin n_fail++; $display("FAIL mid_reset_pre_lit actual=%b required=000", led_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
    n_checks++; if (led_out !== 3'b111 || pwm_wrap !== 1'b0) begin n_fail++; $display("FAIL mid_reset_dark actual=%b wrap=%b required=111/0", led_out, pwm_wrap); end
    bad = 0;
    while (!pwm_wrap && cyc < 600) begin
      step();
      if (led_out !== 3'b111) bad++;
    end
    n_checks++; if (cyc != 256) begin n_fail++; $display("FAIL mid_reset_cnt_restart actual_cyc=%0d required=256", cyc); end
    for (int i = 0; i < 300; i++) begin
      step();
      if (led_out !== 3'b111) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_reset_modes_off lit_cycles=%0d required=0", bad); end
  endtask

  initial begin
    test_reset();
    test_pwm_duty();
    test_shadow();
    test_blink();
    test_edges();
    test_prescale();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
